// File: rtl/result_collector_if.sv
// Result collector bus: MLP result handshake, golden-ROM lookup and scoring outputs.
// Handshake: `ready` is a level held high while the MLP presents `label`;
// one result is taken per low->high transition of `ready` seen on a clk_en
// cycle. There is no back-pressure, and the collector never stalls the producer.
// When RESULT_COLLECTOR_CLASS_ERR_EN is defined, the bus also carries the
// per-class error query signals err_class_sel / err_class_count.
interface result_collector_if #(
  parameter int clog2_size_of_output_layer = 4,
  parameter int clog2_number_of_test_cases = 10
);
  logic [clog2_size_of_output_layer-1:0] label;
  logic                                  ready;
  logic [clog2_size_of_output_layer-1:0] expected_label;
  logic [clog2_number_of_test_cases-1:0] index;
  logic [clog2_number_of_test_cases-1:0] correct_count;
  logic                                  last_mismatch;
  logic                                  done;
`ifdef RESULT_COLLECTOR_CLASS_ERR_EN
  logic [clog2_size_of_output_layer-1:0] err_class_sel;
  logic [clog2_number_of_test_cases-1:0] err_class_count;

  // Producer / bench side.
  modport master (
    output label, ready, expected_label, err_class_sel,
    input  index, correct_count, last_mismatch, done, err_class_count
  );

  // Collector side.
  modport slave (
    input  label, ready, expected_label, err_class_sel,
    output index, correct_count, last_mismatch, done, err_class_count
  );
`else
  // Producer / bench side.
  modport master (
    output label, ready, expected_label,
    input  index, correct_count, last_mismatch, done
  );

  // Collector side.
  modport slave (
    input  label, ready, expected_label,
    output index, correct_count, last_mismatch, done
  );
`endif
endinterface

// File: rtl/result_collector.sv
// result_collector: scores a run of MLP classifications against a golden ROM.
// Each rising edge of `ready` (seen on a clk_en cycle) accepts one result,
// compares it with expected_label, and advances the ROM index. After
// number_of_test_cases results, `done` rises and the counters freeze until
// `clear` is asserted.
// Optional feature: define RESULT_COLLECTOR_CLASS_ERR_EN to add per-class
// mismatch counters, indexed by expected_label and read through err_class_sel.
module result_collector #(
  parameter int size_of_output_layer       = 10,
  parameter int clog2_size_of_output_layer = 4,
  parameter int number_of_test_cases       = 750,
  parameter int clog2_number_of_test_cases = 10
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active low
  input  logic          clk_en,
  input  logic          clear,
  result_collector_if.slave bus,
  output logic          dbg_state   // 0 = COLLECT, 1 = DONE
);

  localparam int LW = clog2_size_of_output_layer;
  localparam int IW = clog2_number_of_test_cases;

  localparam logic [IW-1:0] LAST_INDEX  = IW'(number_of_test_cases - 1);
  localparam logic [LW:0]   NUM_CLASSES = (LW+1)'(size_of_output_layer);
  localparam logic [IW-1:0] ONE_IW      = IW'(1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          ready_prev_q, ready_prev_d;   // registered ready ("ready_d")
  logic [IW-1:0] index_q, index_d;
  logic [IW-1:0] correct_count_q, correct_count_d;
  logic          last_mismatch_q, last_mismatch_d;
  logic          done_q, done_d;

  logic          accept;
  logic          label_in_range;
  logic          match;

  // A result is taken on the first clk_en cycle that sees ready high after low.
  // The comparison uses the ROM output present in that same cycle.
  always_comb begin
    accept         = clk_en && bus.ready && !ready_prev_q && (state_q == ST_COLLECT);
    label_in_range = ({1'b0, bus.label} < NUM_CLASSES);
    match          = label_in_range && (bus.label == bus.expected_label);
  end

  // Next-state logic. clear wins over a concurrent acceptance, and nothing
  // moves while clk_en is low.
  always_comb begin
    state_d         = state_q;
    ready_prev_d    = ready_prev_q;
    index_d         = index_q;
    correct_count_d = correct_count_q;
    last_mismatch_d = last_mismatch_q;
    done_d          = done_q;

    if (clk_en) begin
      if (clear) begin
        state_d         = ST_COLLECT;
        ready_prev_d    = 1'b0;
        index_d         = '0;
        correct_count_d = '0;
        last_mismatch_d = 1'b0;
        done_d          = 1'b0;
      end else begin
        ready_prev_d = bus.ready;
        if (accept) begin
          if (match) begin
            correct_count_d = correct_count_q + ONE_IW;
          end
          last_mismatch_d = !match;
          // The final result leaves the index on the last ROM entry.
          if (index_q == LAST_INDEX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + ONE_IW;
          end
        end
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_COLLECT;
      ready_prev_q    <= 1'b0;
      index_q         <= '0;
      correct_count_q <= '0;
      last_mismatch_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ready_prev_q    <= ready_prev_d;
      index_q         <= index_d;
      correct_count_q <= correct_count_d;
      last_mismatch_q <= last_mismatch_d;
      done_q          <= done_d;
    end
  end

  assign bus.index         = index_q;
  assign bus.correct_count = correct_count_q;
  assign bus.last_mismatch = last_mismatch_q;
  assign bus.done          = done_q;
  assign dbg_state         = state_q;

`ifdef RESULT_COLLECTOR_CLASS_ERR_EN
  logic [IW-1:0] err_cnt_q [size_of_output_layer];
  logic [IW-1:0] err_cnt_d [size_of_output_layer];
  logic          exp_in_range;
  logic          sel_in_range;

  // Mismatches are charged to the golden class. Out-of-range golden labels
  // have no counter and are dropped.
  always_comb begin
    exp_in_range = ({1'b0, bus.expected_label} < NUM_CLASSES);
    err_cnt_d    = err_cnt_q;
    if (clk_en) begin
      if (clear) begin
        for (int i = 0; i < size_of_output_layer; i++) begin
          err_cnt_d[i] = '0;
        end
      end else if (accept && !match && exp_in_range) begin
        err_cnt_d[bus.expected_label] = err_cnt_q[bus.expected_label] + ONE_IW;
      end
    end
  end

  // Per-class counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < size_of_output_layer; i++) begin
        err_cnt_q[i] <= '0;
      end
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Combinational readback; an out-of-range selector reads as zero.
  always_comb begin
    sel_in_range        = ({1'b0, bus.err_class_sel} < NUM_CLASSES);
    bus.err_class_count = '0;
    if (sel_in_range) begin
      bus.err_class_count = err_cnt_q[bus.err_class_sel];
    end
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed pulses with literal expectations, plus
// a result-level scoreboard model checked against the DUT every cycle.
module tb_result_collector;

  localparam int NCLS = 10;
  localparam int LW   = 4;
  localparam int NTC  = 750;
  localparam int IW   = 10;

  logic clk;
  logic rst;
  logic clk_en;
  logic clear;
  logic dbg_state;

  int checks = 0;
  int errors = 0;

  result_collector_if #(
    .clog2_size_of_output_layer(LW),
    .clog2_number_of_test_cases(IW)
  ) bus ();

  result_collector #(
    .size_of_output_layer      (NCLS),
    .clog2_size_of_output_layer(LW),
    .number_of_test_cases      (NTC),
    .clog2_number_of_test_cases(IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .clear    (clear),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  // The model counts accepted results; index and done follow from that count.
  int m_taken;
  int m_correct;
  bit m_mis;
  bit m_prev_ready;
  int m_err [NCLS];

  task automatic model_zero();
    m_taken      = 0;
    m_correct    = 0;
    m_mis        = 1'b0;
    m_prev_ready = 1'b0;
    for (int i = 0; i < NCLS; i++) m_err[i] = 0;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial model_zero();

  // Advance the model at each rising edge, then compare 1 time unit later.
  always @(posedge clk) begin
    int  lbl;
    int  exp_lbl;
    bit  ok;
    int  exp_index;
    lbl     = int'(bus.label);
    exp_lbl = int'(bus.expected_label);
    if (!rst) begin
      model_zero();
    end else if (clk_en) begin
      if (clear) begin
        model_zero();
      end else begin
        if (bus.ready && !m_prev_ready && m_taken < NTC) begin
          ok = (lbl < NCLS) && (lbl == exp_lbl);
          m_taken++;
          if (ok) m_correct++;
          m_mis = !ok;
          if (!ok && exp_lbl < NCLS) m_err[exp_lbl]++;
        end
        m_prev_ready = bus.ready;
      end
    end
    #1;
    exp_index = (m_taken == NTC) ? NTC - 1 : m_taken;
    check("model_index", int'(bus.index), exp_index);
    check("model_correct", int'(bus.correct_count), m_correct);
    check("model_last_mismatch", int'(bus.last_mismatch), int'(m_mis));
    check("model_done", int'(bus.done), int'(m_taken == NTC));
    check("model_state", int'(dbg_state), int'(m_taken == NTC));
`ifdef RESULT_COLLECTOR_CLASS_ERR_EN
    check("model_err_class", int'(bus.err_class_count),
          (int'(bus.err_class_sel) < NCLS) ? m_err[int'(bus.err_class_sel)] : 0);
`endif
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Present a result with ready held high for `hold` cycles, then drop it.
  task automatic pulse(input int lbl, input int exp_lbl, input int hold);
    bus.label          = LW'(lbl);
    bus.expected_label = LW'(exp_lbl);
    bus.ready          = 1'b1;
    repeat (hold) tick();
    bus.ready = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic check_outs(input string tag, input int idx, input int cc,
                            input int mis, input int dn);
    check({tag, "_index"}, int'(bus.index), idx);
    check({tag, "_correct"}, int'(bus.correct_count), cc);
    check({tag, "_last_mismatch"}, int'(bus.last_mismatch), mis);
    check({tag, "_done"}, int'(bus.done), dn);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lbl;
    int exp_lbl;
    rst                = 1'b0;
    clk_en             = 1'b1;
    clear              = 1'b0;
    bus.label          = '0;
    bus.expected_label = '0;
    bus.ready          = 1'b0;
`ifdef RESULT_COLLECTOR_CLASS_ERR_EN
    bus.err_class_sel  = LW'(4);
`endif
    repeat (2) tick();
    check_outs("reset", 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    // Ready held five cycles counts once.
    pulse(3, 3, 5);
    check_outs("hold5", 1, 1, 0, 0);

    // Wrong class, then an out-of-range label that equals the golden value.
    pulse(7, 2, 1);
    check_outs("mismatch", 2, 1, 1, 0);
    pulse(15, 15, 1);
    check_outs("label15", 3, 1, 1, 0);
    pulse(5, 5, 1);
    check_outs("recover", 4, 2, 0, 0);

    // Ready edge while clk_en is low is seen only once clk_en returns.
    bus.label          = LW'(1);
    bus.expected_label = LW'(1);
    clk_en    = 1'b0;
    bus.ready = 1'b1;
    repeat (2) tick();
    check_outs("clken_off", 4, 2, 0, 0);
    clk_en = 1'b1;
    tick();
    check_outs("clken_on", 5, 3, 0, 0);
    bus.ready = 1'b0;
    tick();

    // clear together with a ready edge discards the result.
    bus.label          = LW'(2);
    bus.expected_label = LW'(2);
    bus.ready = 1'b1;
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
    bus.ready = 1'b0;
    check_outs("clear_edge", 0, 0, 0, 0);
    tick();
    check_outs("clear_after", 0, 0, 0, 0);

    // Reset mid-run at index 37; ready already high at release is taken.
    for (int i = 0; i < 37; i++) pulse(i % NCLS, i % NCLS, 1);
    check_outs("run37", 37, 37, 0, 0);
    bus.label          = LW'(4);
    bus.expected_label = LW'(4);
    bus.ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_outs("release_accept", 1, 1, 0, 0);
    bus.ready = 1'b0;
    tick();

`ifdef RESULT_COLLECTOR_CLASS_ERR_EN
    // Three misses charged to golden class 4.
    do_clear();
    for (int i = 0; i < 3; i++) pulse(1, 4, 1);
    bus.err_class_sel = LW'(4);
    #1 check("err_sel4", int'(bus.err_class_count), 3);
    bus.err_class_sel = LW'(12);
    #1 check("err_sel12", int'(bus.err_class_count), 0);
    bus.err_class_sel = LW'(4);
`endif

    // Full run: 750 results, every 15th one wrong (50 misses).
    do_clear();
    check_outs("pre_full", 0, 0, 0, 0);
    for (int i = 0; i < NTC; i++) begin
      lbl     = i % NCLS;
      exp_lbl = (i % 15 == 0) ? (lbl + 1) % NCLS : lbl;
      pulse(lbl, exp_lbl, 1 + (i % 3));
    end
    check_outs("full_run", 749, 700, 0, 1);
    pulse(0, 9, 1);
    check_outs("after_done", 749, 700, 0, 1);

    do_clear();
    check_outs("clear_done", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter size_of_output_layer, default 10, the number of output classes.
REQ-002 SHALL have parameter clog2_size_of_output_layer, default 4, the label width.
REQ-003 SHALL have parameter number_of_test_cases, default 750, the test vectors per run.
REQ-004 SHALL have parameter clog2_number_of_test_cases, default 10, the index and count width.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clk_en  input  1  global clock enable; state frozen when 0.
REQ-008 SHALL have port clear  input  1  synchronous run restart (qualified by clk_en).
REQ-009 SHALL have port label  input  clog2_size_of_output_layer  MLP predicted class.
REQ-010 SHALL have port ready  input  1  MLP result-valid level.
REQ-011 SHALL have port expected_label  input  clog2_size_of_output_layer  golden class for current index, from external ROM.
REQ-012 SHALL have port index  output  clog2_number_of_test_cases  current test index; addresses the golden ROM.
REQ-013 SHALL have port correct_count  output  clog2_number_of_test_cases  matches so far.
REQ-014 SHALL have port last_mismatch  output  1  last accepted result was wrong.
REQ-015 SHALL have port done  output  1  all number_of_test_cases results accepted.

Function
REQ-016 SHALL implement FSM COLLECT, DONE; COLLECT->DONE on acceptance of result number_of_test_cases; DONE->COLLECT only on clear.
REQ-017 SHALL register ready into ready_d on each clk_en cycle; acceptance = clk_en & ready & ~ready_d & state==COLLECT.
REQ-018 SHALL accept ready held high for N cycles exactly once; a new result needs ready to drop for at least one clk_en cycle.
REQ-019 SHALL, on acceptance, compare label to expected_label combinationally in that cycle; match increments correct_count, last_mismatch <= ~match.
REQ-020 SHALL increment index on each acceptance, except the final one, where index holds at number_of_test_cases-1 and done rises.
REQ-021 SHALL make all output updates visible the cycle after the acceptance edge (latency 1).
REQ-022 SHALL count label >= size_of_output_layer as a mismatch.
REQ-023 SHALL ignore ready edges in DONE; counts and index stay frozen.
REQ-024 SHALL make clear take priority over simultaneous acceptance: clear zeroes index, correct_count, last_mismatch, done, ready_d, state=COLLECT; the concurrent result is discarded.
REQ-025 SHALL make no state change when clk_en=0, including ready_d.
REQ-026 SHALL never wrap correct_count; correct_count <= number_of_test_cases holds by construction.

Reset
REQ-027 SHALL, with rst=0, asynchronously force index=0, correct_count=0, last_mismatch=0, done=0, ready_d=0, state=COLLECT.
REQ-028 SHALL, on reset mid-run, lose partial results; collection restarts at index 0 after release.
REQ-029 SHALL accept ready already high at reset release as a new result on the first clk_en cycle (ready_d=0).

Configuration
REQ-030 SHALL, with macro RESULT_COLLECTOR_CLASS_ERR_EN defined, add input err_class_sel (clog2_size_of_output_layer) and output err_class_count (clog2_number_of_test_cases).
REQ-031 SHALL, under that macro, keep size_of_output_layer per-class mismatch counters indexed by expected_label, cleared by reset/clear; err_class_count = counter[err_class_sel] combinationally, 0 if sel out of range.
REQ-032 SHALL, without the macro, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-033 SHALL cover reset: rst=0 mid-run at index 37 -> all outputs 0 asynchronously; after release the first ready pulse is accepted at index 0.
REQ-034 SHALL cover edge detection: ready held high 5 cycles, label=3, expected=3 -> correct_count +1 once, index +1 once.
REQ-035 SHALL cover mismatch: label=7, expected=2 -> last_mismatch=1, correct_count unchanged; label=15 -> mismatch.
REQ-036 SHALL cover full run: 750 pulses, 700 matching -> done=1, correct_count=700, index=749; extra pulse -> no change.
REQ-037 SHALL cover clear vs ready: clear and ready edge in the same cycle -> all zero, result discarded; clk_en=0 during a ready edge -> not accepted until a clk_en cycle sees the edge.
REQ-038 SHALL cover the macro build: 3 errors with expected=4 -> err_class_count=3 with err_class_sel=4, and 0 with sel=12.
